keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter ROW_DWELL, default 8, clock cycles each row is driven (legal range 4..255).
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 4, consecutive identical scan frames required to commit (legal range 1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port col_in  input  4  keypad columns, active-low, asynchronous to clk.
REQ-006 SHALL have port row_out  output  4  keypad row drive, active-low, at most one bit low.
REQ-007 SHALL have port key_onehot  output  16  committed key map; bit i = row*4+col; feeds the downstream one-hot-to-index encoder.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse when key_onehot changes to a nonzero value.
REQ-009 SHALL have port multi_key  output  1  high while key_onehot has more than one bit set.

Function
REQ-010 SHALL pass col_in through a two-flop synchronizer; all sampling uses the synchronized value.
REQ-011 SHALL implement FSM states IDLE, DRIVE, SAMPLE, FRAME_END; IDLE->DRIVE one cycle after reset release.
REQ-012 In DRIVE, row_out SHALL equal ~(4'b0001 << row_idx) for ROW_DWELL-1 cycles (dwell counter 0..ROW_DWELL-2), then move to SAMPLE.
REQ-013 In SAMPLE (one cycle, same row drive), bits [row_idx*4 +: 4] of the frame register SHALL load ~col_sync; row_idx<3 -> increment row_idx, go to DRIVE; row_idx==3 -> FRAME_END.
REQ-014 A full frame SHALL be exactly 4*ROW_DWELL+1 cycles (FRAME_END included); row_idx wraps 3->0 in FRAME_END.
REQ-015 In FRAME_END: frame==prev_frame -> match counter increments, saturating at DEBOUNCE_FRAMES; otherwise match counter resets to 1; prev_frame loads frame.
REQ-016 When match counter reaches DEBOUNCE_FRAMES and frame != key_onehot, key_onehot SHALL load frame on the cycle after FRAME_END.
REQ-017 key_valid SHALL pulse high for exactly the cycle key_onehot updates, only if the new value is nonzero.
REQ-018 multi_key SHALL be registered alongside key_onehot, equal to (popcount of new value > 1); multi-hot values are passed unchanged (encoder reports them as invalid).
REQ-019 row_out SHALL be 4'b1111 in IDLE and FRAME_END.
REQ-020 Release (committed all-zero frame) SHALL follow REQ-016 and REQ-017, subject to Configuration.

Reset
REQ-021 rst high SHALL immediately force: state=IDLE, row_out=4'b1111, key_onehot=16'h0000, key_valid=0, multi_key=0, row_idx=0, counters=0, frame=prev_frame=0, synchronizer=4'b1111.
REQ-022 rst asserted mid-frame SHALL discard the partial frame; scanning restarts at row 0 with match count 0.

Configuration
REQ-023 With KEYPAD_HOLD_EN defined, a committed all-zero frame SHALL NOT update key_onehot or multi_key (last key held until a new nonzero commit).
REQ-024 Without KEYPAD_HOLD_EN, a committed all-zero frame SHALL clear key_onehot and multi_key, with no key_valid pulse.

Verification (ROW_DWELL=4, DEBOUNCE_FRAMES=3, frame=17 cycles)
REQ-025 Assert rst mid-operation -> same cycle row_out=4'hF, key_onehot=16'h0000, key_valid=0, multi_key=0; first row_out=4'hE two cycles after release.
REQ-026 Hold col_in[1] low whenever row_out==4'b1011 -> key_onehot=16'h0200 after the 3rd matching frame, single key_valid pulse, multi_key=0.
REQ-027 Same key alternately present/absent per frame for 6 frames -> key_onehot stays 16'h0000, no key_valid.
REQ-028 Keys 0 and 15 held -> key_onehot=16'h8001, multi_key=1, one key_valid pulse.
REQ-029 Release key 9 after commit -> without KEYPAD_HOLD_EN key_onehot=16'h0000 after 3 frames, no pulse; with it key_onehot stays 16'h0200.
REQ-030 Hold key 9 for 20 frames -> exactly one key_valid pulse total; row_out never has more than one low bit.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with frame-level debounce.
//
// Drives one keypad row low at a time, samples the synchronized columns at
// the end of each row dwell and assembles a 16-bit frame (bit = row*4+col).
// A frame is committed to key_onehot once DEBOUNCE_FRAMES consecutive
// identical frames have been seen and it differs from the current output.
//
// Parameters:
//   ROW_DWELL        clock cycles per row (4..255); frame = 4*ROW_DWELL+1
//   DEBOUNCE_FRAMES  identical frames needed to commit (1..15)
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous, active-high reset
//   col_in      keypad columns, active-low, asynchronous to clk
//   row_out     keypad row drive, active-low, at most one bit low
//   key_onehot  committed key map, bit i = row*4+col
//   key_valid   one-cycle pulse when key_onehot takes a new nonzero value
//   multi_key   high while key_onehot has more than one bit set
//
// Build option:
//   KEYPAD_HOLD_EN  when defined, a committed all-zero frame leaves
//                   key_onehot/multi_key untouched (last key is held).

module keypad_scanner #(
  parameter int unsigned ROW_DWELL       = 8,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic [15:0] key_onehot,
  output logic        key_valid,
  output logic        multi_key
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StDrive    = 2'd1;
  localparam logic [1:0] StSample   = 2'd2;
  localparam logic [1:0] StFrameEnd = 2'd3;

  localparam logic [7:0] DwellLast = 8'(ROW_DWELL - 2);
  localparam logic [3:0] MatchMax  = 4'(DEBOUNCE_FRAMES);

`ifdef KEYPAD_HOLD_EN
  localparam bit HoldOnRelease = 1'b1;
`else
  localparam bit HoldOnRelease = 1'b0;
`endif

  logic [3:0]  col_meta_q, col_sync_q;
  logic [1:0]  state_q, state_d;
  logic [1:0]  row_idx_q, row_idx_d;
  logic [7:0]  dwell_q, dwell_d;
  logic [15:0] frame_q, frame_d;
  logic [15:0] prev_frame_q, prev_frame_d;
  logic [3:0]  match_q, match_d;
  logic [15:0] key_onehot_q, key_onehot_d;
  logic        key_valid_q, key_valid_d;
  logic        multi_key_q, multi_key_d;
  logic [3:0]  row_out_q, row_out_d;

  // Two-flop synchronizer; idles high (no key) so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta_q <= 4'b1111;
      col_sync_q <= 4'b1111;
    end else begin
      col_meta_q <= col_in;
      col_sync_q <= col_meta_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    row_idx_d    = row_idx_q;
    dwell_d      = dwell_q;
    frame_d      = frame_q;
    prev_frame_d = prev_frame_q;
    match_d      = match_q;
    key_onehot_d = key_onehot_q;
    key_valid_d  = 1'b0;
    multi_key_d  = multi_key_q;

    case (state_q)
      StIdle: begin
        state_d   = StDrive;
        row_idx_d = 2'd0;
        dwell_d   = 8'd0;
      end

      StDrive: begin
        if (dwell_q == DwellLast) begin
          dwell_d = 8'd0;
          state_d = StSample;
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end

      StSample: begin
        frame_d[{row_idx_q, 2'b00} +: 4] = ~col_sync_q;
        if (row_idx_q == 2'd3) begin
          state_d = StFrameEnd;
        end else begin
          row_idx_d = row_idx_q + 2'd1;
          state_d   = StDrive;
        end
      end

      StFrameEnd: begin
        state_d      = StDrive;
        row_idx_d    = 2'd0;
        prev_frame_d = frame_q;
        if (frame_q == prev_frame_q) begin
          match_d = (match_q >= MatchMax) ? MatchMax : match_q + 4'd1;
        end else begin
          match_d = 4'd1;
        end
        // Commit lands on the edge closing FRAME_END, so the new map is
        // visible during the first cycle of the next frame.
        if ((match_d == MatchMax) && (frame_q != key_onehot_q)) begin
          if (frame_q != 16'h0000) begin
            key_onehot_d = frame_q;
            multi_key_d  = (frame_q & (frame_q - 16'd1)) != 16'h0000;
            key_valid_d  = 1'b1;
          end else if (!HoldOnRelease) begin
            key_onehot_d = 16'h0000;
            multi_key_d  = 1'b0;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Row drive registered from next state: glitch-free, yet aligned with state_q.
  always_comb begin
    row_out_d = 4'b1111;
    if ((state_d == StDrive) || (state_d == StSample)) begin
      row_out_d = ~(4'b0001 << row_idx_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      row_idx_q    <= 2'd0;
      dwell_q      <= 8'd0;
      frame_q      <= 16'h0000;
      prev_frame_q <= 16'h0000;
      match_q      <= 4'd0;
      key_onehot_q <= 16'h0000;
      key_valid_q  <= 1'b0;
      multi_key_q  <= 1'b0;
      row_out_q    <= 4'b1111;
    end else begin
      state_q      <= state_d;
      row_idx_q    <= row_idx_d;
      dwell_q      <= dwell_d;
      frame_q      <= frame_d;
      prev_frame_q <= prev_frame_d;
      match_q      <= match_d;
      key_onehot_q <= key_onehot_d;
      key_valid_q  <= key_valid_d;
      multi_key_q  <= multi_key_d;
      row_out_q    <= row_out_d;
    end
  end

  assign row_out    = row_out_q;
  assign key_onehot = key_onehot_q;
  assign key_valid  = key_valid_q;
  assign multi_key  = multi_key_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with ROW_DWELL=4, DEBOUNCE_FRAMES=3
// (17-cycle frames). A behavioural keypad pulls a column low whenever a
// pressed key sits on the currently driven row.

module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [15:0] key_onehot;
  logic        key_valid;
  logic        multi_key;

  logic [15:0] keys;
  int          tests = 0;
  int          fails = 0;
  int          pulse_cnt = 0;
  int          bad_row = 0;

`ifdef KEYPAD_HOLD_EN
  localparam logic [15:0] ExpAfterRelease = 16'h0200;
`else
  localparam logic [15:0] ExpAfterRelease = 16'h0000;
`endif

  keypad_scanner #(
    .ROW_DWELL       (4),
    .DEBOUNCE_FRAMES (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .col_in     (col_in),
    .row_out    (row_out),
    .key_onehot (key_onehot),
    .key_valid  (key_valid),
    .multi_key  (multi_key)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row_out[r]) begin
        for (int c = 0; c < 4; c++) begin
          if (keys[r*4+c]) col_in[c] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && key_valid) pulse_cnt++;
    if ($countones(~row_out) > 1) bad_row++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n frames, landing just after the negedge in the first cycle of a frame.
  task automatic frames(input int n);
    repeat (17 * n) @(negedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    keys = 16'h0000;
    repeat (3) @(negedge clk);
    #1;
    check("rst_row_out", 32'(row_out), 32'hF);
    check("rst_key_onehot", 32'(key_onehot), 32'h0);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_multi_key", 32'(multi_key), 32'h0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_row_out", 32'(row_out), 32'hF);
    @(negedge clk);
    #1;
    check("first_row_out", 32'(row_out), 32'hE);

    // Key 9 (row 2, col 1) from frame 1; commits after frame 3.
    keys = 16'h0200;
    frames(2);
    check("k9_not_early", 32'(key_onehot), 32'h0);
    frames(1);
    check("k9_onehot", 32'(key_onehot), 32'h0200);
    check("k9_valid", 32'(key_valid), 32'h1);
    check("k9_multi", 32'(multi_key), 32'h0);
    frames(1);
    check("k9_valid_once", 32'(key_valid), 32'h0);
    frames(16);
    check("k9_hold20_onehot", 32'(key_onehot), 32'h0200);
    check("k9_hold20_pulses", 32'(pulse_cnt), 32'd1);

    // Release key 9 at frame 21; the empty frame commits after frame 23.
    keys = 16'h0000;
    frames(2);
    check("rel_not_early", 32'(key_onehot), 32'h0200);
    frames(1);
    check("rel_onehot", 32'(key_onehot), 32'(ExpAfterRelease));
    check("rel_multi", 32'(multi_key), 32'h0);
    check("rel_no_pulse", 32'(pulse_cnt), 32'd1);

    // Key 5 bouncing every frame never gathers three matching frames.
    for (int i = 0; i < 6; i++) begin
      keys = (i % 2 == 0) ? 16'h0020 : 16'h0000;
      frames(1);
    end
    check("bounce_onehot", 32'(key_onehot), 32'(ExpAfterRelease));
    check("bounce_pulses", 32'(pulse_cnt), 32'd1);

    // Keys 0 and 15 together.
    keys = 16'h8001;
    frames(3);
    check("k0k15_onehot", 32'(key_onehot), 32'h8001);
    check("k0k15_multi", 32'(multi_key), 32'h1);
    check("k0k15_valid", 32'(key_valid), 32'h1);
    check("k0k15_pulses", 32'(pulse_cnt), 32'd2);

    // Mid-frame reset with a committed multi-key value.
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_row_out", 32'(row_out), 32'hF);
    check("mid_rst_onehot", 32'(key_onehot), 32'h0);
    check("mid_rst_valid", 32'(key_valid), 32'h0);
    check("mid_rst_multi", 32'(multi_key), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rerel_idle_row", 32'(row_out), 32'hF);
    @(negedge clk);
    #1;
    check("rerel_first_row", 32'(row_out), 32'hE);
    frames(2);
    check("rescan_not_early", 32'(key_onehot), 32'h0);
    frames(1);
    check("rescan_onehot", 32'(key_onehot), 32'h8001);
    check("rescan_valid", 32'(key_valid), 32'h1);
    check("row_drive_onehot", 32'(bad_row), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
